// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// state encoding and default parameter values.
package rr_mux_arbiter_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_HOLD_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_e;

  // Grant state belonging to a requester index (0 -> G0, 1 -> G1).
  function automatic arb_state_e grant_state(input logic idx);
    return idx ? ST_G1 : ST_G0;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// WIDTH-bit combinational 2:1 mux for the shared datapath (sel: 0 = i0, 1 = i1).
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? i1 : i0;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter owning the select of a shared 2:1 mux;
// registers the selected data onto y with a valid flag.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  // Handshake: a requester holds req high until it sees its gnt; while gnt is
  // high its data on i0/i1 is captured into y every cycle, including the
  // cycle in which it drops req. Requests are never latched.

  localparam int              CNT_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic             last, last_nx;
  logic             sel_nx;
  logic             hold_at_lim;
  logic [WIDTH-1:0] mux_y;

  assign hold_at_lim = (hold_cnt == CNT_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      sel      <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      last     <= last_nx;
      sel      <= sel_nx;
    end
  end

  // Release is checked before preemption, so a drop on the limit cycle still
  // hands over in a single step.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (req0 && req1)  state_nx = grant_state(~last);
        else if (req0)     state_nx = ST_G0;
        else if (req1)     state_nx = ST_G1;
      end
      ST_G0: begin
        if (!req0)                     state_nx = req1 ? ST_G1 : ST_IDLE;
        else if (req1 && hold_at_lim)  state_nx = ST_G1;
      end
      ST_G1: begin
        if (!req1)                     state_nx = req0 ? ST_G0 : ST_IDLE;
        else if (req0 && hold_at_lim)  state_nx = ST_G0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_nx = hold_cnt;
    last_nx = last;
    sel_nx  = sel;
    if (state_nx != state)
      hold_nx = '0;
    else if (state != ST_IDLE && !hold_at_lim)
      hold_nx = hold_cnt + CNT_ONE;
    // sel and last only move on grant; IDLE keeps the shared path steady.
    case (state_nx)
      ST_G0: begin
        last_nx = 1'b0;
        sel_nx  = 1'b0;
      end
      ST_G1: begin
        last_nx = 1'b1;
        sel_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt0 = (state == ST_G0);
  assign gnt1 = (state == ST_G1);

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .i0  (i0),
    .i1  (i1),
    .sel (sel),
    .y   (mux_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (state != ST_IDLE) begin
      y       <= mux_y;
      y_valid <= 1'b1;
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule
